// File: rtl/nv_nvdla_glb_cacc_intr_if.sv
// Register access bus between a CSR master and the CACC interrupt collector.
// Read data comes back one cycle after the read strobe, qualified by reg_rd_valid.
interface nv_nvdla_glb_cacc_intr_if;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wr_data;
    logic [31:0] reg_rd_data;
    logic        reg_rd_valid;

    modport master (
        output reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
        input  reg_rd_data, reg_rd_valid
    );

    modport slave (
        input  reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
        output reg_rd_data, reg_rd_valid
    );
endinterface

// File: rtl/nv_nvdla_glb_cacc_intr.sv
// CACC done-event interrupt collector: sticky status, overflow flags, saturating
// per-group event counters, a mask register and a registered level interrupt.
module nv_nvdla_glb_cacc_intr #(
    parameter int CNT_W = 16
) (
    input  logic                          nvdla_core_clk,
    input  logic                          nvdla_core_rst,
    input  logic [1:0]                    i_cacc2glb_done_intr_dst_pd,
    output logic                          o_cacc_intr,
    nv_nvdla_glb_cacc_intr_if.slave       if_reg
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_status;
    logic [1:0]       r_ovf;
    logic [1:0]       r_mask;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;
    logic             r_intr;
    logic [31:0]      r_rdData;
    logic             r_rdValid;

    logic             w_wrStatus;
    logic             w_wrMask;
    logic             w_wrCnt0;
    logic             w_wrCnt1;
    logic [1:0]       w_pd;
    logic [1:0]       w_statusClr;
    logic [1:0]       w_ovfClr;
    logic [1:0]       w_statusNext;
    logic [1:0]       w_ovfNext;
    logic [1:0]       w_maskNext;
    logic [CNT_W-1:0] w_cnt0Next;
    logic [CNT_W-1:0] w_cnt1Next;
    logic [31:0]      w_rdMux;
    logic             w_unusedWrData;

    assign w_pd       = i_cacc2glb_done_intr_dst_pd;
    assign w_wrStatus = if_reg.reg_wr_en && (if_reg.reg_addr == 2'd0);
    assign w_wrMask   = if_reg.reg_wr_en && (if_reg.reg_addr == 2'd1);
    assign w_wrCnt0   = if_reg.reg_wr_en && (if_reg.reg_addr == 2'd2);
    assign w_wrCnt1   = if_reg.reg_wr_en && (if_reg.reg_addr == 2'd3);

    assign w_statusClr = w_wrStatus ? if_reg.reg_wr_data[1:0] : 2'b00;
    assign w_ovfClr    = w_wrStatus ? if_reg.reg_wr_data[3:2] : 2'b00;

    // A new pulse always wins over W1C; overflow looks at status as held before this edge.
    assign w_statusNext = (r_status & ~w_statusClr) | w_pd;
    assign w_ovfNext    = (r_ovf & ~w_ovfClr) | (w_pd & r_status);
    assign w_maskNext   = w_wrMask ? if_reg.reg_wr_data[1:0] : r_mask;

    assign w_unusedWrData = ^if_reg.reg_wr_data[31:4];

    // A clear that coincides with a pulse leaves the counter at one, not zero.
    always_comb begin
        w_cnt0Next = r_cnt0;
        if (w_wrCnt0) begin
            w_cnt0Next = w_pd[0] ? CNT_ONE : '0;
        end else if (w_pd[0] && (r_cnt0 != CNT_MAX)) begin
            w_cnt0Next = r_cnt0 + CNT_ONE;
        end
    end

    always_comb begin
        w_cnt1Next = r_cnt1;
        if (w_wrCnt1) begin
            w_cnt1Next = w_pd[1] ? CNT_ONE : '0;
        end else if (w_pd[1] && (r_cnt1 != CNT_MAX)) begin
            w_cnt1Next = r_cnt1 + CNT_ONE;
        end
    end

    always_comb begin
        w_rdMux = 32'd0;
        case (if_reg.reg_addr)
            2'd0:    w_rdMux = {28'd0, r_ovf, r_status};
            2'd1:    w_rdMux = {30'd0, r_mask};
            2'd2:    w_rdMux = 32'(r_cnt0);
            default: w_rdMux = 32'(r_cnt1);
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_status  <= 2'b00;
            r_ovf     <= 2'b00;
            r_mask    <= 2'b00;
            r_cnt0    <= '0;
            r_cnt1    <= '0;
            r_intr    <= 1'b0;
            r_rdData  <= 32'd0;
            r_rdValid <= 1'b0;
        end else begin
            r_status  <= w_statusNext;
            r_ovf     <= w_ovfNext;
            r_mask    <= w_maskNext;
            r_cnt0    <= w_cnt0Next;
            r_cnt1    <= w_cnt1Next;
            r_intr    <= |(w_statusNext & ~w_maskNext);
            r_rdValid <= if_reg.reg_rd_en;
            if (if_reg.reg_rd_en) begin
                r_rdData <= w_rdMux;
            end
        end
    end

    assign o_cacc_intr         = r_intr;
    assign if_reg.reg_rd_data  = r_rdData;
    assign if_reg.reg_rd_valid = r_rdValid;

endmodule

// File: tb/tb_nv_nvdla_glb_cacc_intr.sv
// Directed bench for the CACC interrupt collector (CNT_W=4 so saturation is reachable).
// Table rows are one clock each; expected values are the outputs after the sampling edge.
module tb_nv_nvdla_glb_cacc_intr;

    typedef struct {
        logic [1:0]  pd;
        logic        wrEn;
        logic        rdEn;
        logic [1:0]  addr;
        logic [31:0] wrData;
        logic        expIntr;
        logic        chkData;
        logic [31:0] expData;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [1:0] pd;
    logic       intr;
    int         nChecks;
    int         nFails;

    nv_nvdla_glb_cacc_intr_if regIf ();

    nv_nvdla_glb_cacc_intr #(.CNT_W(4)) dut (
        .nvdla_core_clk              (clk),
        .nvdla_core_rst              (rst),
        .i_cacc2glb_done_intr_dst_pd (pd),
        .o_cacc_intr                 (intr),
        .if_reg                      (regIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t row(input logic [1:0] p, input logic w, input logic r,
                                 input logic [1:0] a, input logic [31:0] d,
                                 input logic ei, input logic cd, input logic [31:0] ed);
        vec_t v;
        v.pd = p; v.wrEn = w; v.rdEn = r; v.addr = a; v.wrData = d;
        v.expIntr = ei; v.chkData = cd; v.expData = ed;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        pd = 2'b00;
        regIf.reg_wr_en = 1'b0;
        regIf.reg_rd_en = 1'b0;
        regIf.reg_addr = 2'd0;
        regIf.reg_wr_data = 32'd0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        pd = v.pd;
        regIf.reg_wr_en = v.wrEn;
        regIf.reg_rd_en = v.rdEn;
        regIf.reg_addr = v.addr;
        regIf.reg_wr_data = v.wrData;
        tick();
        idleInputs();
        checkOutput($sformatf("row%0d intr", idx), 32'(intr), 32'(v.expIntr));
        checkOutput($sformatf("row%0d rd_valid", idx), 32'(regIf.reg_rd_valid), 32'(v.rdEn));
        if (v.chkData) begin
            checkOutput($sformatf("row%0d rd_data", idx), regIf.reg_rd_data, v.expData);
        end
    endtask

    task automatic doRead(input logic [1:0] a, input logic [31:0] exp, input string name);
        regIf.reg_rd_en = 1'b1;
        regIf.reg_addr = a;
        tick();
        idleInputs();
        checkOutput({name, " valid"}, 32'(regIf.reg_rd_valid), 32'd1);
        checkOutput(name, regIf.reg_rd_data, exp);
    endtask

    task automatic doWrite(input logic [1:0] a, input logic [31:0] d, input logic [1:0] p);
        regIf.reg_wr_en = 1'b1;
        regIf.reg_addr = a;
        regIf.reg_wr_data = d;
        pd = p;
        tick();
        idleInputs();
    endtask

    vec_t vecs[34];

    initial begin
        nChecks = 0;
        nFails = 0;
        rst = 1'b1;
        idleInputs();

        // pd, wr, rd, addr, wrData, expIntr, chkData, expData
        vecs[0]  = row(2'b01, 0, 0, 2'd0, 32'h0,        1, 0, 32'h0);
        vecs[1]  = row(2'b00, 0, 1, 2'd0, 32'h0,        1, 1, 32'h1);
        vecs[2]  = row(2'b00, 0, 1, 2'd2, 32'h0,        1, 1, 32'h1);
        vecs[3]  = row(2'b00, 1, 0, 2'd0, 32'h1,        0, 0, 32'h0);
        vecs[4]  = row(2'b00, 0, 1, 2'd0, 32'h0,        0, 1, 32'h0);
        vecs[5]  = row(2'b00, 1, 0, 2'd2, 32'h0,        0, 0, 32'h0);
        vecs[6]  = row(2'b01, 0, 0, 2'd0, 32'h0,        1, 0, 32'h0);
        vecs[7]  = row(2'b01, 0, 0, 2'd0, 32'h0,        1, 0, 32'h0);
        vecs[8]  = row(2'b00, 0, 1, 2'd0, 32'h0,        1, 1, 32'h5);
        vecs[9]  = row(2'b00, 0, 1, 2'd2, 32'h0,        1, 1, 32'h2);
        vecs[10] = row(2'b00, 1, 0, 2'd0, 32'h4,        1, 0, 32'h0);
        vecs[11] = row(2'b00, 0, 1, 2'd0, 32'h0,        1, 1, 32'h1);
        vecs[12] = row(2'b00, 1, 0, 2'd0, 32'h1,        0, 0, 32'h0);
        vecs[13] = row(2'b00, 0, 1, 2'd0, 32'h0,        0, 1, 32'h0);
        vecs[14] = row(2'b00, 1, 0, 2'd1, 32'h3,        0, 0, 32'h0);
        vecs[15] = row(2'b11, 0, 0, 2'd0, 32'h0,        0, 0, 32'h0);
        vecs[16] = row(2'b00, 0, 1, 2'd0, 32'h0,        0, 1, 32'h3);
        vecs[17] = row(2'b00, 0, 1, 2'd1, 32'h0,        0, 1, 32'h3);
        vecs[18] = row(2'b00, 1, 0, 2'd1, 32'h1,        1, 0, 32'h0);
        vecs[19] = row(2'b00, 0, 1, 2'd0, 32'h0,        1, 1, 32'h3);
        vecs[20] = row(2'b00, 1, 0, 2'd0, 32'h3,        0, 0, 32'h0);
        vecs[21] = row(2'b00, 1, 0, 2'd1, 32'h0,        0, 0, 32'h0);
        vecs[22] = row(2'b00, 0, 1, 2'd3, 32'h0,        0, 1, 32'h1);
        vecs[23] = row(2'b01, 1, 0, 2'd0, 32'h1,        1, 0, 32'h0);
        vecs[24] = row(2'b00, 0, 1, 2'd0, 32'h0,        1, 1, 32'h1);
        vecs[25] = row(2'b01, 1, 0, 2'd0, 32'h1,        1, 0, 32'h0);
        vecs[26] = row(2'b00, 0, 1, 2'd0, 32'h0,        1, 1, 32'h5);
        vecs[27] = row(2'b01, 1, 0, 2'd0, 32'h5,        1, 0, 32'h0);
        vecs[28] = row(2'b00, 0, 1, 2'd0, 32'h0,        1, 1, 32'h5);
        vecs[29] = row(2'b00, 1, 0, 2'd0, 32'hF,        0, 0, 32'h0);
        vecs[30] = row(2'b00, 1, 1, 2'd1, 32'hFFFFFFFE, 0, 1, 32'h0);
        vecs[31] = row(2'b00, 0, 1, 2'd1, 32'h0,        0, 1, 32'h2);
        vecs[32] = row(2'b00, 0, 0, 2'd0, 32'h0,        0, 1, 32'h2);
        vecs[33] = row(2'b00, 1, 0, 2'd1, 32'h0,        0, 1, 32'h2);

        repeat (3) tick();
        checkOutput("reset intr", 32'(intr), 32'd0);
        checkOutput("reset rd_valid", 32'(regIf.reg_rd_valid), 32'd0);
        checkOutput("reset rd_data", regIf.reg_rd_data, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 34; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Count saturation on group1, then clear coinciding with a pulse.
        doWrite(2'd3, 32'h0, 2'b00);
        for (int i = 0; i < 17; i++) begin
            pd = 2'b10;
            tick();
        end
        pd = 2'b00;
        checkOutput("sat intr", 32'(intr), 32'd1);
        doRead(2'd3, 32'd15, "COUNT1 saturated");
        doRead(2'd0, 32'h8 | 32'h2, "STATUS after burst");
        doWrite(2'd3, 32'h0, 2'b10);
        doRead(2'd3, 32'd1, "COUNT1 clear+pulse");
        doWrite(2'd2, 32'h0, 2'b00);
        doRead(2'd2, 32'd0, "COUNT0 cleared");

        // Reset mid-traffic with a mask set and status pending.
        doWrite(2'd1, 32'h1, 2'b01);
        pd = 2'b11;
        regIf.reg_rd_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst intr", 32'(intr), 32'd0);
        checkOutput("midrst rd_valid", 32'(regIf.reg_rd_valid), 32'd0);
        checkOutput("midrst rd_data", regIf.reg_rd_data, 32'd0);
        tick();
        idleInputs();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("postrst intr", 32'(intr), 32'd0);
        doRead(2'd1, 32'd0, "postrst MASK");
        doRead(2'd0, 32'd0, "postrst STATUS");
        doRead(2'd2, 32'd0, "postrst COUNT0");
        doRead(2'd3, 32'd0, "postrst COUNT1");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
